// File: rtl/motion_pkg.sv
// ----------------------------------------------------------------------------
// motion_pkg : shared widths, defaults and quadrature phase encoding for the
//              encoder emulator and its quadrature decoder models.
// Revision   : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package motion_pkg;

  localparam int COUNTS_PER_REV = 1496;
  localparam int FRAC_W         = 8;
  localparam int VEL_W          = 16;
  localparam int POS_W          = 16;
  localparam int MAX_VEL        = 128;

  typedef enum logic [1:0] {
    QUAD_S0 = 2'd0,
    QUAD_S1 = 2'd1,
    QUAD_S2 = 2'd2,
    QUAD_S3 = 2'd3
  } quad_phase_t;

  // {A,B} per phase: forward rotation walks 00 -> 10 -> 11 -> 01, A leads B
  localparam logic [1:0] QUAD_AB_S0 = 2'b00;
  localparam logic [1:0] QUAD_AB_S1 = 2'b10;
  localparam logic [1:0] QUAD_AB_S2 = 2'b11;
  localparam logic [1:0] QUAD_AB_S3 = 2'b01;

  function automatic logic [1:0] quad_ab(input quad_phase_t phase);
    logic [1:0] ab;
    case (phase)
      QUAD_S0: ab = QUAD_AB_S0;
      QUAD_S1: ab = QUAD_AB_S1;
      QUAD_S2: ab = QUAD_AB_S2;
      default: ab = QUAD_AB_S3;
    endcase
    return ab;
  endfunction

endpackage

`default_nettype wire

// File: rtl/quad_decode_state.sv
// ----------------------------------------------------------------------------
// quad_decode_state : registers quadrature A/B and index from a position value.
// Revision          : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module quad_decode_state
  import motion_pkg::*;
#(
  parameter int POS_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [POS_W-1:0] pos_next,
  output logic             a,
  output logic             b,
  output logic             index
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a     <= 1'b0;
      b     <= 1'b0;
      index <= 1'b1;
    end else begin
      {a, b} <= quad_ab(quad_phase_t'(pos_next[1:0]));
      index  <= (pos_next == '0);
    end
  end

endmodule

`default_nettype wire

// File: rtl/encoder_emulator.sv
// ----------------------------------------------------------------------------
// encoder_emulator : integrates a clamped Q8.8 velocity into a wrapped shaft
//                    position with matching quadrature A/B/index outputs.
// Revision         : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module encoder_emulator #(
  parameter int COUNTS_PER_REV = motion_pkg::COUNTS_PER_REV,
  parameter int VEL_W          = motion_pkg::VEL_W,
  parameter int FRAC_W         = motion_pkg::FRAC_W,
  parameter int MAX_VEL        = motion_pkg::MAX_VEL
) (
  input  logic                                 i_clk,
  input  logic                                 i_reset,
  input  logic                                 i_enable,
  input  logic signed [VEL_W-1:0]              i_velocity,
  input  logic                                 i_load,
  input  logic        [motion_pkg::POS_W-1:0]  i_load_value,
  output logic        [motion_pkg::POS_W-1:0]  o_position,
  output logic                                 o_a,
  output logic                                 o_b,
  output logic                                 o_index,
  output logic                                 o_dir,
  output logic                                 o_overspeed,
  output logic                                 o_load_err
);

  localparam int POS_W = motion_pkg::POS_W;
  // Two integer bits above the fraction hold acc + v_q (|x| <= 383)
  localparam int ACC_W = FRAC_W + 2;

  localparam logic        [POS_W-1:0] LAST_POS = POS_W'(COUNTS_PER_REV - 1);
  localparam logic        [POS_W-1:0] CPR_POS  = POS_W'(COUNTS_PER_REV);
  localparam logic signed [ACC_W-1:0] STEP_POS = ACC_W'(1 << FRAC_W);
  localparam logic signed [ACC_W-1:0] STEP_NEG = -STEP_POS;
  localparam logic signed [VEL_W-1:0] VEL_HI   = VEL_W'(MAX_VEL);
  localparam logic signed [VEL_W-1:0] VEL_LO   = -VEL_HI;

  logic signed [ACC_W-1:0] v_q;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] acc_nxt;
  logic signed [VEL_W-1:0] vel_clamped;
  logic                    vel_over;
  logic        [POS_W-1:0] pos_nxt;
  logic                    dir_nxt;
  logic                    load_err_nxt;
  logic                    load_ok;

  always_comb begin
    vel_clamped = i_velocity;
    vel_over    = 1'b0;
    if (i_velocity > VEL_HI) begin
      vel_clamped = VEL_HI;
      vel_over    = 1'b1;
    end else if (i_velocity < VEL_LO) begin
      vel_clamped = VEL_LO;
      vel_over    = 1'b1;
    end
  end

  assign load_ok = (i_load_value < CPR_POS);
  assign acc_sum = acc + v_q;

  // A rejected load only raises the error flag; integration proceeds normally
  always_comb begin
    pos_nxt      = o_position;
    acc_nxt      = acc;
    dir_nxt      = o_dir;
    load_err_nxt = 1'b0;
    if (i_load && load_ok) begin
      pos_nxt = i_load_value;
      acc_nxt = '0;
    end else begin
      load_err_nxt = i_load;
      if (i_enable) begin
        if (acc_sum >= STEP_POS) begin
          acc_nxt = acc_sum - STEP_POS;
          pos_nxt = (o_position == LAST_POS) ? '0 : o_position + POS_W'(1);
          dir_nxt = 1'b0;
        end else if (acc_sum <= STEP_NEG) begin
          acc_nxt = acc_sum + STEP_POS;
          pos_nxt = (o_position == '0) ? LAST_POS : o_position - POS_W'(1);
          dir_nxt = 1'b1;
        end else begin
          acc_nxt = acc_sum;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      v_q         <= '0;
      acc         <= '0;
      o_position  <= '0;
      o_dir       <= 1'b0;
      o_overspeed <= 1'b0;
      o_load_err  <= 1'b0;
    end else begin
      v_q         <= vel_clamped[ACC_W-1:0];
      o_overspeed <= vel_over;
      acc         <= acc_nxt;
      o_position  <= pos_nxt;
      o_dir       <= dir_nxt;
      o_load_err  <= load_err_nxt;
    end
  end

  quad_decode_state #(
    .POS_W (POS_W)
  ) u_quad (
    .clk      (i_clk),
    .rst      (i_reset),
    .pos_next (pos_nxt),
    .a        (o_a),
    .b        (o_b),
    .index    (o_index)
  );

endmodule

`default_nettype wire

// File: tb/tb_encoder_emulator.sv
// ----------------------------------------------------------------------------
// tb_encoder_emulator : directed + randomized bench with a reference model.
// Revision            : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_encoder_emulator;

  localparam int CPR = 1496;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic signed [15:0] velocity;
  logic               load;
  logic        [15:0] load_value;
  logic        [15:0] position;
  logic               a, b, index, dir, overspeed, load_err;

  int check_count = 0;
  int pass_count  = 0;

  // reference model state: plain integers, one count = 256 velocity units
  int m_acc, m_vq, m_pos;
  bit m_dir, m_ovs, m_lerr;
  logic [1:0] ab_tbl [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  always #5 clk = ~clk;

  encoder_emulator dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_enable     (enable),
    .i_velocity   (velocity),
    .i_load       (load),
    .i_load_value (load_value),
    .o_position   (position),
    .o_a          (a),
    .o_b          (b),
    .o_index      (index),
    .o_dir        (dir),
    .o_overspeed  (overspeed),
    .o_load_err   (load_err)
  );

  task automatic model_reset();
    m_acc = 0; m_vq = 0; m_pos = 0;
    m_dir = 0; m_ovs = 0; m_lerr = 0;
  endtask

  task automatic model_edge();
    int sum, step, v, lv;
    sum  = m_acc + m_vq;
    step = 0;
    lv   = int'(load_value);
    m_lerr = 0;
    if (load && lv < CPR) begin
      m_pos = lv;
      m_acc = 0;
    end else begin
      m_lerr = load;
      if (enable) begin
        if (sum >= 256)       begin step = 1;  m_acc = sum - 256; end
        else if (sum <= -256) begin step = -1; m_acc = sum + 256; end
        else                  m_acc = sum;
      end
    end
    if (step != 0) begin
      m_pos = (m_pos + step + CPR) % CPR;
      m_dir = (step < 0);
    end
    v     = int'(velocity);
    m_ovs = (v > 128) || (v < -128);
    m_vq  = (v > 128) ? 128 : ((v < -128) ? -128 : v);
  endtask

  task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic check_all();
    logic [1:0] ab;
    ab = ab_tbl[m_pos % 4];
    check1("position",  {16'd0, position}, m_pos);
    check1("quad_a",    {31'd0, a},         {31'd0, ab[1]});
    check1("quad_b",    {31'd0, b},         {31'd0, ab[0]});
    check1("index",     {31'd0, index},     {31'd0, (m_pos == 0)});
    check1("dir",       {31'd0, dir},       {31'd0, m_dir});
    check1("overspeed", {31'd0, overspeed}, {31'd0, m_ovs});
    check1("load_err",  {31'd0, load_err},  {31'd0, m_lerr});
  endtask

  task automatic cycle(input bit en, input int vel, input bit ld, input int lv);
    enable     = en;
    velocity   = 16'(vel);
    load       = ld;
    load_value = 16'(lv);
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1 check_all();
  endtask

  // asynchronous reset asserted between edges, checked before any clock
  task automatic async_reset(input int hold_cycles);
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    for (int i = 0; i < hold_cycles; i++) cycle(1'b1, 64, 1'b0, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic int rand_vel();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 256)) - 128;
      1:       return int'($urandom_range(0, 65535)) - 32768;
      2:       return 0;
      default: return int'($urandom_range(0, 600)) - 300;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int found;
    rst = 1'b1; enable = 1'b0; velocity = '0; load = 1'b0; load_value = '0;
    #1 model_reset();
    check_all();
    cycle(1'b0, 0, 1'b0, 0);
    cycle(1'b0, 0, 1'b0, 0);
    @(negedge clk);
    rst = 1'b0;

    // steady v=64: one count every 4 cycles, A/B walks forward
    for (int i = 0; i < 44; i++) cycle(1'b1, 64, 1'b0, 0);

    // forward wrap through the index at full speed
    cycle(1'b1, 128, 1'b1, 1494);
    for (int i = 0; i < 8; i++) cycle(1'b1, 128, 1'b0, 0);

    // reverse wrap
    cycle(1'b1, -128, 1'b1, 1);
    for (int i = 0; i < 8; i++) cycle(1'b1, -128, 1'b0, 0);

    // overspeed clamp both directions
    for (int i = 0; i < 6; i++) cycle(1'b1, 1000, 1'b0, 0);
    for (int i = 0; i < 6; i++) cycle(1'b1, -32768, 1'b0, 0);

    // out-of-range load while stepping, then a load coinciding with a crossing
    for (int i = 0; i < 3; i++) cycle(1'b1, 128, 1'b0, 0);
    cycle(1'b1, 128, 1'b1, 1496);
    for (int i = 0; i < 3; i++) cycle(1'b1, 128, 1'b0, 0);
    found = 0;
    for (int i = 0; i < 8 && found == 0; i++) begin
      if (m_acc + m_vq >= 256) begin
        cycle(1'b1, 128, 1'b1, 5);
        found = 1;
        check1("load_at_crossing", {16'd0, position}, 32'd5);
      end else begin
        cycle(1'b1, 128, 1'b0, 0);
      end
    end
    check1("crossing_found", found, 32'd1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 128, 1'b0, 0);

    // disable freezes, zero velocity holds residue, sign change counts back
    for (int i = 0; i < 4; i++) cycle(1'b0, 100, 1'b0, 0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 0, 1'b0, 0);
    for (int i = 0; i < 6; i++) cycle(1'b1, -90, 1'b0, 0);

    // reset in the middle of operation at position 700
    cycle(1'b1, 64, 1'b1, 700);
    cycle(1'b1, 64, 1'b0, 0);
    async_reset(3);
    for (int i = 0; i < 6; i++) cycle(1'b1, 128, 1'b0, 0);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 149) == 0) async_reset(int'($urandom_range(1, 3)));
      cycle($urandom_range(0, 3) != 0, rand_vel(),
            $urandom_range(0, 15) == 0, int'($urandom_range(0, 1600)));
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/encoder_emulator.md
Name: encoder_emulator

Overview:
Converts a signed velocity command into a wrapped shaft position modulo COUNTS_PER_REV (default 1496). Also produces the matching quadrature A/B and index signals. This is the generator side of the wrapped-position stream our velocity-profile logic consumes. It drives the motion/S-curve datapath in closed-loop simulation and on-board loopback, replacing a physical encoder.

Parameters:
- COUNTS_PER_REV, 1496, counts per revolution; must be a multiple of 4.
- VEL_W, 16, width of the signed velocity input.
- FRAC_W, 8, fractional bits of velocity (units of 1/256 count per clock).
- MAX_VEL, 128, magnitude clamp in velocity LSBs; 128 gives at most one count per 2 clocks.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_enable  in  1  1 = integrate velocity; 0 = freeze accumulator and position.
- i_velocity  in  16  signed two's-complement, Q8.8 counts/clock.
- i_load  in  1  single-cycle pulse: preset position.
- i_load_value  in  16  unsigned preset; valid range 0..COUNTS_PER_REV-1.
- o_position  out  16  current position, 0..COUNTS_PER_REV-1.
- o_a  out  1  quadrature channel A.
- o_b  out  1  quadrature channel B.
- o_index  out  1  high while o_position==0.
- o_dir  out  1  direction of last step; 0 = forward, 1 = reverse.
- o_overspeed  out  1  high in cycles where the registered velocity was clamped.
- o_load_err  out  1  one-cycle pulse: load rejected (value out of range).

Behaviour:
- Reset (async, immediate):
  - Accumulator and v_q = 0.
  - o_position = 0, o_a = 0, o_b = 0, o_index = 1.
  - o_dir = 0, o_overspeed = 0, o_load_err = 0.
- Stage 1, every edge regardless of enable: v_q <= clamp(i_velocity, -MAX_VEL, +MAX_VEL). Overspeed flag registered alongside v_q and driven on o_overspeed.
- Stage 2 accumulator:
  - Signed, 10 bits (range -383..+383 suffices).
  - When enabled: acc_next = acc + v_q.
  - If acc_next >= 256: step +1, acc <= acc_next - 256.
  - Else if acc_next <= -256: step -1, acc <= acc_next + 256.
  - Else no step, acc <= acc_next.
  - At most one step per cycle; guaranteed by the clamp.
- Latency: a velocity applied before edge N first affects acc at edge N+1. A step is visible on o_position at the same edge acc crosses the threshold.
- Position wrap:
  - Step +1: 1495 -> 0, else +1.
  - Step -1: 0 -> 1495, else -1.
  - No other modular arithmetic.
- o_dir updates only on a step: 0 for +1, 1 for -1. It holds when there is no step.
- Quadrature outputs are registered from the next position, so they are aligned with o_position.
  - pos mod 4 = 0 -> A=0 B=0; 1 -> A=1 B=0; 2 -> A=1 B=1; 3 -> A=0 B=1.
  - Forward rotation therefore has A leading B.
  - Wrap is glitch-free because COUNTS_PER_REV mod 4 = 0.
- Load (priority over stepping in the same cycle):
  - If i_load_value < COUNTS_PER_REV: position <= value, acc <= 0, no step that cycle, o_dir unchanged.
  - Else: position and acc unchanged, o_load_err = 1 for the next cycle only.
  - A load is honoured even when i_enable = 0.
- Disable: acc and position hold. v_q and o_overspeed keep tracking the input.
- Velocity 0: acc holds its residue, so position holds. A sign change mid-residue counts back from the held residue; no reset of acc.
- Reset mid-operation: everything returns asynchronously to reset values. The first step after reset release needs a full 256 of accumulated velocity.

Decomposition:
- Shared package (motion_pkg) holds:
  - COUNTS_PER_REV
  - FRAC_W
  - Velocity and position widths
  - Quadrature state encoding constants
- Natural sub-module: quad_decode_state. It maps position mod 4 to registered A/B/index and is reused by the future quadrature decoder bench model.

Test Plan:
1. Assert i_reset for 3 cycles mid-run at pos 700 -> outputs immediately read pos=0, A=B=0, index=1, dir=0.
2. Enable, v=64 -> pos increments every 4 cycles; pos=10 after 40 cycles following first acc update; A/B sequence 00,10,11,01,00.
3. Load 1494, v=+128 -> pos 1494,1495,0,1 at 2-cycle spacing; index high exactly 2 cycles; dir=0.
4. Load 1, v=-128 -> pos 0,1495,1494; dir=1 after first step; A/B order 10,00,01,11.
5. v=1000 -> o_overspeed=1 one cycle after the input; rate 1 count per 2 cycles. v=-32768 -> clamp -128, overspeed=1.
6. Load 1496 with v=+128 running -> o_load_err pulses 1 cycle, stepping continues unaffected. Then load 5 simultaneous with a threshold crossing -> pos=5, acc=0, no step that cycle.
